// File: rtl/alu_cmd_sequencer.sv
// Collects UART bytes into ALU operands and an opcode, presents them to an external
// combinational ALU, and streams the result back out one byte at a time, least significant first.
module alu_cmd_sequencer #(
  parameter  int NB_DATA        = 8,
  parameter  int NB_BYTES       = 2,
  parameter  int NB_OP          = 6,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int NB_OPERAND     = NB_DATA * NB_BYTES
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx_valid,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_tx_done,
  input  logic [NB_OPERAND-1:0] i_result,
  output logic [NB_OPERAND-1:0] o_data_a,
  output logic [NB_OPERAND-1:0] o_data_b,
  output logic [NB_OP-1:0]      o_operation,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_tx_data,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_timeout,
  output logic                  o_drop
);

  localparam int NB_IDX = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam int NB_TO  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [NB_IDX-1:0] IDX_LAST = NB_IDX'(NB_BYTES - 1);
  localparam logic [NB_TO-1:0]  TO_LAST  = NB_TO'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, LATCH, TX_LOAD, TX_WAIT} state_t;

  state_t                  state, state_next;
  logic [NB_IDX-1:0]       idx, idx_next;
  logic [NB_TO-1:0]        cnt, cnt_next;
  logic [NB_OPERAND-1:0]   shadow_a, shadow_b, result_sr, result_shifted;
  logic                    partial, accept, drop, expire, tx_advance, frame_end;

  // The idle timer only runs once at least one byte of the current frame has arrived.
  assign partial        = ((state == RX_A) && (idx != '0)) || (state == RX_B) || (state == RX_OP);
  assign result_shifted = result_sr >> NB_DATA;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= RX_A;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      cnt   <= cnt_next;
    end
  end

  // idx counts received operand bytes in RX states and transmitted result bytes in TX states.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = '0;
    accept     = 1'b0;
    drop       = 1'b0;
    expire     = 1'b0;
    tx_advance = 1'b0;
    frame_end  = 1'b0;
    o_busy     = 1'b0;
    o_tx_start = 1'b0;
    case (state)
      RX_A, RX_B, RX_OP: begin
        if (i_rx_valid) begin
          accept = 1'b1;
          if (state == RX_OP) begin
            state_next = LATCH;
          end else if (idx == IDX_LAST) begin
            idx_next   = '0;
            state_next = (state == RX_A) ? RX_B : RX_OP;
          end else begin
            idx_next = idx + 1'b1;
          end
        end else if ((TIMEOUT_CYCLES != 0) && partial) begin
          if (cnt == TO_LAST) begin
            expire     = 1'b1;
            idx_next   = '0;
            state_next = RX_A;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      LATCH: begin
        o_busy     = 1'b1;
        drop       = i_rx_valid;
        state_next = TX_LOAD;
      end
      TX_LOAD: begin
        o_busy     = 1'b1;
        o_tx_start = 1'b1;
        drop       = i_rx_valid;
        state_next = TX_WAIT;
      end
      TX_WAIT: begin
        o_busy = 1'b1;
        drop   = i_rx_valid;
        if (i_tx_done) begin
          if (idx == IDX_LAST) begin
            frame_end  = 1'b1;
            idx_next   = '0;
            state_next = RX_A;
          end else begin
            tx_advance = 1'b1;
            idx_next   = idx + 1'b1;
            state_next = TX_LOAD;
          end
        end
      end
      default: begin
        state_next = RX_A;
        idx_next   = '0;
      end
    endcase
  end

  // o_tx_data is loaded one cycle ahead of each TX_LOAD so the byte is stable with the strobe.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      shadow_a     <= '0;
      shadow_b     <= '0;
      result_sr    <= '0;
      o_data_a     <= '0;
      o_data_b     <= '0;
      o_operation  <= '0;
      o_tx_data    <= '0;
      o_frame_done <= 1'b0;
      o_timeout    <= 1'b0;
      o_drop       <= 1'b0;
    end else begin
      o_frame_done <= frame_end;
      o_timeout    <= expire;
      o_drop       <= drop;
      if (accept) begin
        case (state)
          RX_A:    shadow_a[idx*NB_DATA +: NB_DATA] <= i_rx_data;
          RX_B:    shadow_b[idx*NB_DATA +: NB_DATA] <= i_rx_data;
          default: begin
            o_data_a    <= shadow_a;
            o_data_b    <= shadow_b;
            o_operation <= i_rx_data[NB_OP-1:0];
          end
        endcase
      end
      if (state == LATCH) begin
        result_sr <= i_result;
        o_tx_data <= i_result[NB_DATA-1:0];
      end else if (tx_advance) begin
        result_sr <= result_shifted;
        o_tx_data <= result_shifted[NB_DATA-1:0];
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a stub ALU drives i_result, expected result
// bytes and decoded frames are queued at stimulus time and checked by a monitor.
module tb_alu_cmd_sequencer;

  localparam int NB_DATA    = 8;
  localparam int NB_BYTES   = 2;
  localparam int NB_OP      = 6;
  localparam int TIMEOUT    = 16;
  localparam int NB_OPERAND = NB_DATA * NB_BYTES;

  logic                  i_clock;
  logic                  i_reset;
  logic                  i_rx_valid;
  logic [NB_DATA-1:0]    i_rx_data;
  logic                  i_tx_done;
  logic [NB_OPERAND-1:0] i_result;
  logic [NB_OPERAND-1:0] o_data_a;
  logic [NB_OPERAND-1:0] o_data_b;
  logic [NB_OP-1:0]      o_operation;
  logic                  o_tx_start;
  logic [NB_DATA-1:0]    o_tx_data;
  logic                  o_busy;
  logic                  o_frame_done;
  logic                  o_timeout;
  logic                  o_drop;

  typedef struct {
    int a;
    int b;
    int op;
  } frame_t;

  frame_t exp_frames[$];
  int     exp_tx[$];
  frame_t mon_f;
  int     checks = 0;
  int     errors = 0;
  int     frames_expected = 0;
  int     frames_seen = 0;
  int     timeouts_expected = 0;
  int     timeouts_seen = 0;
  int     drops_expected = 0;
  int     drops_seen = 0;
  int     last_a = 0;
  logic   tx_auto = 1'b1;
  logic   tx_done_auto = 1'b0;
  logic   tx_done_manual = 1'b0;

  assign i_tx_done = tx_done_auto | tx_done_manual;

  alu_cmd_sequencer #(
    .NB_DATA(NB_DATA),
    .NB_BYTES(NB_BYTES),
    .NB_OP(NB_OP),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_rx_valid(i_rx_valid),
    .i_rx_data(i_rx_data),
    .i_tx_done(i_tx_done),
    .i_result(i_result),
    .o_data_a(o_data_a),
    .o_data_b(o_data_b),
    .o_operation(o_operation),
    .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data),
    .o_busy(o_busy),
    .o_frame_done(o_frame_done),
    .o_timeout(o_timeout),
    .o_drop(o_drop)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Stand-in ALU; the sequencer only transports whatever it returns.
  function automatic int alu_model(input int a, input int b, input int op);
    case (op)
      'h20:    return (a + b) & 'hFFFF;
      'h22:    return (a - b) & 'hFFFF;
      'h24:    return a & b;
      'h25:    return a | b;
      'h26:    return a ^ b;
      'h02:    return (a << (b % 16)) & 'hFFFF;
      default: return (~(a | b)) & 'hFFFF;
    endcase
  endfunction

  assign i_result = NB_OPERAND'(alu_model(int'(o_data_a), int'(o_data_b), int'(o_operation)));

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic send_byte(input int b);
    i_rx_valid = 1'b1;
    i_rx_data  = b[7:0];
    tick(1);
    i_rx_valid = 1'b0;
  endtask

  task automatic push_expect(input int a, input int b, input int op_byte);
    frame_t f;
    int     r;
    f.a  = a;
    f.b  = b;
    f.op = op_byte & 'h3F;
    r    = alu_model(a, b, f.op);
    exp_frames.push_back(f);
    frames_expected++;
    for (int k = 0; k < NB_BYTES; k++) exp_tx.push_back((r >> (8 * k)) & 'hFF);
    last_a = a;
  endtask

  // Sends one full frame; returns in the cycle right after the opcode byte is accepted.
  task automatic apply_stimulus(input int a, input int b, input int op_byte, input int max_gap);
    int bytes[5];
    push_expect(a, b, op_byte);
    bytes[0] = a & 'hFF;
    bytes[1] = (a >> 8) & 'hFF;
    bytes[2] = b & 'hFF;
    bytes[3] = (b >> 8) & 'hFF;
    bytes[4] = op_byte & 'hFF;
    for (int i = 0; i < 5; i++) begin
      send_byte(bytes[i]);
      if (i < 4) tick(int'($urandom_range(0, max_gap)));
    end
  endtask

  task automatic wait_frames(input string name);
    int n = 0;
    while (frames_seen < frames_expected && n < 300) begin
      tick(1);
      n++;
    end
    check_output(name, frames_seen, frames_expected);
  endtask

  // Transmitter stand-in: acknowledges each started byte after a random delay.
  initial begin
    forever begin
      @(negedge i_clock);
      if (o_tx_start && tx_auto) begin
        tick(int'($urandom_range(1, 4)));
        tx_done_auto = 1'b1;
        tick(1);
        tx_done_auto = 1'b0;
      end
    end
  end

  always @(negedge i_clock) begin
    if (i_reset) begin
      if (o_tx_start) begin
        if (exp_tx.size() == 0) check_output("tx_start_unexpected", o_tx_start, exp_tx.size() > 0);
        else check_output("tx_byte", o_tx_data, exp_tx.pop_front());
      end
      if (o_frame_done) begin
        frames_seen++;
        if (exp_frames.size() == 0) begin
          check_output("frame_done_unexpected", o_frame_done, exp_frames.size() > 0);
        end else begin
          mon_f = exp_frames.pop_front();
          check_output("frame_a", o_data_a, mon_f.a);
          check_output("frame_b", o_data_b, mon_f.b);
          check_output("frame_op", o_operation, mon_f.op);
        end
      end
      if (o_timeout) timeouts_seen++;
      if (o_drop) drops_seen++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ops[7] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h02, 'h3F};
    int a, b, op_byte;
    i_reset    = 1'b0;
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
    tick(3);
    check_output("reset_data_a", o_data_a, 0);
    check_output("reset_data_b", o_data_b, 0);
    check_output("reset_operation", o_operation, 0);
    check_output("reset_tx_data", o_tx_data, 0);
    check_output("reset_busy", o_busy, 0);
    check_output("reset_tx_start", o_tx_start, 0);
    i_reset = 1'b1;
    tick(1);
    check_output("post_reset_tx_start", o_tx_start, 0);

    $display("[TB] stray tx_done while idle");
    tx_done_manual = 1'b1;
    tick(1);
    tx_done_manual = 1'b0;
    check_output("stray_done_busy", o_busy, 0);
    tick(1);
    check_output("stray_done_tx_start", o_tx_start, 0);

    $display("[TB] basic add frame and latency");
    apply_stimulus('h1234, 'h0002, 'h20, 0);
    check_output("t1_data_a", o_data_a, 'h1234);
    check_output("t1_data_b", o_data_b, 'h0002);
    check_output("t1_operation", o_operation, 'h20);
    check_output("t1_busy", o_busy, 1);
    check_output("t1_no_tx_start", o_tx_start, 0);
    tick(1);
    check_output("t2_tx_start", o_tx_start, 1);
    check_output("t2_tx_data", o_tx_data, 'h36);
    wait_frames("frame_add");

    $display("[TB] opcode upper bits ignored");
    apply_stimulus('h00FF, 'h0F0F, 'hE5, 2);
    check_output("op_masked", o_operation, 'h25);
    wait_frames("frame_or");

    $display("[TB] partial frame timeout");
    send_byte('h11);
    tick(15);
    check_output("timeout_not_yet", o_timeout, 0);
    tick(1);
    timeouts_expected++;
    check_output("timeout_pulse", o_timeout, 1);
    check_output("timeout_data_a_kept", o_data_a, last_a);
    check_output("timeout_busy", o_busy, 0);
    tick(1);
    check_output("timeout_one_cycle", o_timeout, 0);
    apply_stimulus('h0001, 'h0001, 'h20, 3);
    wait_frames("frame_after_timeout");

    $display("[TB] byte in expiry cycle");
    push_expect('h2211, 'h0005, 'h22);
    send_byte('h11);
    tick(15);
    send_byte('h22);
    send_byte('h05);
    send_byte('h00);
    send_byte('h22);
    wait_frames("frame_expiry_byte");
    check_output("no_timeout_on_expiry_byte", timeouts_seen, timeouts_expected);

    $display("[TB] byte while busy is dropped");
    apply_stimulus('hA5A5, 'h0F0F, 'h24, 1);
    send_byte('h55);
    drops_expected++;
    check_output("drop_pulse", o_drop, 1);
    check_output("drop_tx_start", o_tx_start, 1);
    check_output("drop_tx_data", o_tx_data, 'h05);
    wait_frames("frame_with_drop");

    $display("[TB] reset during transmission");
    tx_auto = 1'b0;
    apply_stimulus('hBEEF, 'h0101, 'h26, 1);
    tick(2);
    check_output("pre_reset_busy", o_busy, 1);
    i_reset = 1'b0;
    #1;
    check_output("rst_data_a", o_data_a, 0);
    check_output("rst_data_b", o_data_b, 0);
    check_output("rst_operation", o_operation, 0);
    check_output("rst_tx_data", o_tx_data, 0);
    check_output("rst_busy", o_busy, 0);
    check_output("rst_tx_start", o_tx_start, 0);
    exp_tx.delete();
    exp_frames.delete();
    frames_expected = frames_seen;
    tick(2);
    i_reset = 1'b1;
    tx_auto = 1'b1;
    tick(1);
    check_output("rst_release_tx_start", o_tx_start, 0);
    check_output("rst_release_busy", o_busy, 0);
    apply_stimulus('h4321, 'h1111, 'h22, 2);
    wait_frames("frame_after_reset");

    $display("[TB] randomized frames");
    for (int n = 0; n < 25; n++) begin
      a       = int'($urandom_range(0, 'hFFFF));
      b       = int'($urandom_range(0, 'hFFFF));
      op_byte = ops[$urandom_range(0, 6)] | (int'($urandom_range(0, 3)) << 6);
      apply_stimulus(a, b, op_byte, 3);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) tick(1);
        send_byte(int'($urandom_range(0, 255)));
        drops_expected++;
      end
      wait_frames("frame_random");
    end

    tick(5);
    check_output("timeout_count", timeouts_seen, timeouts_expected);
    check_output("drop_count", drops_seen, drops_expected);
    check_output("tx_queue_drained", exp_tx.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter NB_DATA, default 8: UART byte width.
REQ-002 Parameter NB_BYTES, default 2: bytes per operand and per result; operand width NB_OPERAND = NB_DATA*NB_BYTES.
REQ-003 Parameter NB_OP, default 6: opcode width; NB_OP <= NB_DATA.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: max idle clocks between bytes of one frame; 0 disables the timeout.
REQ-005 i_clock  input  1  single clock, all state on rising edge.
REQ-006 i_reset  input  1  asynchronous, active-low reset.
REQ-007 i_rx_valid  input  1  one-cycle strobe, received byte valid.
REQ-008 i_rx_data  input  NB_DATA  received byte.
REQ-009 i_tx_done  input  1  one-cycle strobe, transmitter finished current byte.
REQ-010 i_result  input  NB_OPERAND  combinational ALU result for the current o_data_a/o_data_b/o_operation.
REQ-011 o_data_a, o_data_b  output  NB_OPERAND  operands to ALU.
REQ-012 o_operation  output  NB_OP  opcode to ALU.
REQ-013 o_tx_start  output  1  one-cycle strobe, start transmitting o_tx_data.
REQ-014 o_tx_data  output  NB_DATA  byte to transmit.
REQ-015 o_busy  output  1  high while result bytes are being transmitted.
REQ-016 o_frame_done, o_timeout, o_drop  output  1 each  one-cycle status pulses.

Function
REQ-017 Frame = NB_BYTES bytes of A, NB_BYTES bytes of B, one opcode byte; operand bytes least-significant first; opcode = i_rx_data[NB_OP-1:0], upper bits ignored.
REQ-018 States: RX_A, RX_B, RX_OP, LATCH, TX_LOAD, TX_WAIT; byte index counter 0..NB_BYTES-1.
REQ-019 RX_A/RX_B: each i_rx_valid writes byte[index] into a shadow register; after byte NB_BYTES-1, index clears and state advances (RX_A->RX_B, RX_B->RX_OP).
REQ-020 Shadow registers are not visible on outputs; o_data_a, o_data_b, o_operation update together in the cycle after the opcode byte is accepted (atomic update) and hold until the next opcode accept.
REQ-021 RX_OP + i_rx_valid -> LATCH; LATCH lasts exactly one cycle and samples i_result into a result shift register.
REQ-022 TX_LOAD: assert o_tx_start for one cycle with o_tx_data = result byte 0 (LSB), go to TX_WAIT.
REQ-023 TX_WAIT: on i_tx_done, shift result by NB_DATA; if bytes remain -> TX_LOAD (next o_tx_start one cycle after i_tx_done), else pulse o_frame_done and -> RX_A.
REQ-024 Latency: opcode accepted in cycle t -> ALU outputs valid t+1, result sampled end of t+1, first o_tx_start in t+2.
REQ-025 o_busy high in LATCH, TX_LOAD, TX_WAIT; low otherwise.
REQ-026 i_rx_valid during LATCH/TX_LOAD/TX_WAIT: byte discarded, o_drop pulses same cycle+1; state unaffected.
REQ-027 i_tx_done outside TX_WAIT is ignored.
REQ-028 Timeout counter clears on every accepted byte; counts only when a frame is partially received (RX_A with index>0, RX_B, RX_OP); held at 0 otherwise.
REQ-029 Counter reaching TIMEOUT_CYCLES: discard partial frame, index=0, -> RX_A, o_timeout pulses one cycle; outputs o_data_a/b/o_operation unchanged.
REQ-030 i_rx_valid in the same cycle the counter would expire: byte accepted, no timeout.
REQ-031 o_tx_data holds its last value between strobes.

Reset
REQ-032 i_reset low asynchronously forces RX_A, index 0, counter 0, all data outputs and shadow/result registers 0, all strobes and o_busy 0, including mid-frame and mid-transmission; no o_tx_start in the first cycle after release.

Verification
REQ-033 Defaults; send 0x34,0x12,0x02,0x00,0x20; i_result=0x1236 -> o_data_a=0x1234, o_data_b=0x0002, o_operation=0x20 one cycle after the last byte; o_tx_start with 0x36, then after i_tx_done 0x12; then o_frame_done.
REQ-034 Opcode byte 0xE5 -> o_operation=0x25.
REQ-035 TIMEOUT_CYCLES=16; send 0x11 then idle 16 cycles -> o_timeout pulse, state RX_A; next frame 0x01,0x00,0x01,0x00,0x20 decodes A=0x0001, B=0x0001.
REQ-036 Byte arriving in exact expiry cycle -> no o_timeout; frame continues.
REQ-037 Send byte 0x55 while o_busy=1 -> o_drop pulse, transmitted bytes and next frame unaffected.
REQ-038 Assert i_reset during TX_WAIT -> all outputs 0 immediately; new frame after release decodes correctly.
